// File: rtl/mlp_pkg.sv
// mlp_pkg: shared widths and defaults for the MLP coprocessor and its result framer
package mlp_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BATCH = 64;
  localparam int COUNT_WIDTH = 16;
endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: first-word-fall-through synchronous FIFO with AXI-Stream handshakes
module axis_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic live;
  logic push, pop;
  assign push = s_valid && s_ready;
  assign pop = m_valid && m_ready;
  assign s_ready = live && (count != (AW+1)'(DEPTH));
  assign m_valid = count != '0;
  assign m_data = m_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr] <= s_data;
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      live <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      live <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/mlp_result_framer.sv
// mlp_result_framer: buffers coprocessor results and re-frames them into BATCH-word TLAST bursts
module mlp_result_framer
  import mlp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BATCH = DEF_BATCH,
  parameter int DEPTH = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   S_AXIS_TVALID,
  input  logic [DATA_WIDTH-1:0]  S_AXIS_TDATA,
  input  logic                   S_AXIS_TLAST,
  output logic                   S_AXIS_TREADY,
  output logic                   M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0]  M_AXIS_TDATA,
  output logic                   M_AXIS_TLAST,
  input  logic                   M_AXIS_TREADY,
  output logic                   batch_done,
  output logic [COUNT_WIDTH-1:0] batch_count
);
  localparam int BW = BATCH > 1 ? $clog2(BATCH) : 1;
  logic [BW-1:0] beat;
  logic fire, fire_last;
  logic unused_tlast;
  assign unused_tlast = S_AXIS_TLAST;
  axis_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .s_valid(S_AXIS_TVALID),
    .s_data(S_AXIS_TDATA),
    .s_ready(S_AXIS_TREADY),
    .m_valid(M_AXIS_TVALID),
    .m_data(M_AXIS_TDATA),
    .m_ready(M_AXIS_TREADY)
  );
  assign M_AXIS_TLAST = M_AXIS_TVALID && (beat == BW'(BATCH-1));
  assign fire = M_AXIS_TVALID && M_AXIS_TREADY;
  assign fire_last = fire && M_AXIS_TLAST;
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      beat <= '0;
      batch_done <= 1'b0;
      batch_count <= '0;
    end else begin
      batch_done <= fire_last;
      if (fire) beat <= fire_last ? '0 : beat + 1'b1;
      batch_count <= batch_count + COUNT_WIDTH'(fire_last);
    end
  end
endmodule

// File: tb/tb_mlp_result_framer.sv
// tb_mlp_result_framer: randomized and directed checks of three framer instances against a queue model
module tb_mlp_result_framer;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic m_ready = 1'b0;
  logic [31:0] s_data = '0;
  logic s_ready [3];
  logic m_valid [3];
  logic m_last [3];
  logic done [3];
  logic [31:0] m_data [3];
  logic [15:0] bcount [3];
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] q [$];
  int popped = 0;
  int pop_idx = 0;
  bit pop_prev = 0;
  bit live = 0;

  always #5 aclk = ~aclk;

  mlp_result_framer #(.BATCH(4), .DEPTH(16)) u4 (
    .ACLK(aclk), .ARESETN(aresetn), .S_AXIS_TVALID(s_valid), .S_AXIS_TDATA(s_data),
    .S_AXIS_TLAST(s_last), .S_AXIS_TREADY(s_ready[0]), .M_AXIS_TVALID(m_valid[0]),
    .M_AXIS_TDATA(m_data[0]), .M_AXIS_TLAST(m_last[0]), .M_AXIS_TREADY(m_ready),
    .batch_done(done[0]), .batch_count(bcount[0])
  );
  mlp_result_framer #(.BATCH(64), .DEPTH(16)) u64 (
    .ACLK(aclk), .ARESETN(aresetn), .S_AXIS_TVALID(s_valid), .S_AXIS_TDATA(s_data),
    .S_AXIS_TLAST(s_last), .S_AXIS_TREADY(s_ready[1]), .M_AXIS_TVALID(m_valid[1]),
    .M_AXIS_TDATA(m_data[1]), .M_AXIS_TLAST(m_last[1]), .M_AXIS_TREADY(m_ready),
    .batch_done(done[1]), .batch_count(bcount[1])
  );
  mlp_result_framer #(.BATCH(1), .DEPTH(16)) u1 (
    .ACLK(aclk), .ARESETN(aresetn), .S_AXIS_TVALID(s_valid), .S_AXIS_TDATA(s_data),
    .S_AXIS_TLAST(s_last), .S_AXIS_TREADY(s_ready[2]), .M_AXIS_TVALID(m_valid[2]),
    .M_AXIS_TDATA(m_data[2]), .M_AXIS_TLAST(m_last[2]), .M_AXIS_TREADY(m_ready),
    .batch_done(done[2]), .batch_count(bcount[2])
  );

  function automatic int bsz(int i);
    return i == 0 ? 4 : i == 1 ? 64 : 1;
  endfunction

  function automatic bit exp_ready();
    return live && q.size() < 16;
  endfunction

  function automatic bit exp_last(int i);
    return q.size() > 0 && (popped % bsz(i)) == bsz(i) - 1;
  endfunction

  function automatic bit exp_done(int i);
    return pop_prev && (pop_idx % bsz(i)) == bsz(i) - 1;
  endfunction

  function automatic logic [15:0] exp_count(int i);
    return 16'(popped / bsz(i));
  endfunction

  function automatic logic [31:0] exp_data();
    return q.size() > 0 ? q[0] : 32'h0;
  endfunction

  task automatic tick();
    bit push, pop;
    push = s_valid && exp_ready();
    pop = m_ready && q.size() > 0;
    @(posedge aclk);
    if (!aresetn) begin
      q.delete();
      popped = 0;
      live = 0;
      pop_prev = 0;
    end else begin
      pop_prev = pop;
      if (pop) begin
        pop_idx = popped;
        popped++;
        void'(q.pop_front());
      end
      if (push) q.push_back(s_data);
      live = 1;
    end
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    m_ready = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_valid = 1'b1;
    s_data = 32'h1234;
    m_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({s_ready[i], m_valid[i], m_last[i], done[i]} !== 4'b0 || m_data[i] !== 32'h0 || bcount[i] !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: rdy=%b vld=%b last=%b done=%b data=%h cnt=%0d, want all zero",
                 i, s_ready[i], m_valid[i], m_last[i], done[i], m_data[i], bcount[i]);
      end
    end
    s_valid = 1'b0;
    aresetn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (s_ready[i] !== 1'b1 || m_valid[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: rdy=%b vld=%b, want rdy=1 vld=0", i, s_ready[i], m_valid[i]);
      end
    end
  endtask

  task automatic test_streaming();
    int pulses = 0;
    do_reset();
    m_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      s_valid = k <= 5;
      s_data = 32'(k);
      tick();
      pulses += done[0] ? 1 : 0;
      if (k <= 5) begin
        n_tests++;
        if (m_valid[0] !== 1'b1 || m_data[0] !== 32'(k) || m_last[0] !== (k == 4)) begin
          n_fail++;
          $display("FAIL stream_word%0d: vld=%b data=%h last=%b, want 1 %h %b", k, m_valid[0], m_data[0], m_last[0], k, k == 4);
        end
      end
      n_tests++;
      if (done[0] !== (k == 5)) begin
        n_fail++;
        $display("FAIL stream_done@%0d: got %b want %b", k, done[0], k == 5);
      end
    end
    n_tests++;
    if (pulses != 1 || bcount[0] !== 16'd1) begin
      n_fail++;
      $display("FAIL stream_count: pulses=%0d cnt=%0d, want 1 1", pulses, bcount[0]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data = 32'h100 + 32'(i);
      tick();
    end
    s_data = 32'h110;
    tick();
    tick();
    n_tests++;
    if (s_ready[0] !== 1'b0 || m_data[0] !== 32'h100) begin
      n_fail++;
      $display("FAIL bp_full: rdy=%b head=%h, want 0 100", s_ready[0], m_data[0]);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (m_valid[0] !== 1'b1 || m_data[0] !== 32'h100 + 32'(i)) begin
        n_fail++;
        $display("FAIL bp_drain%0d: vld=%b data=%h want %h", i, m_valid[0], m_data[0], 32'h100 + 32'(i));
      end
      if (i == 0) begin
        n_tests++;
        if (s_ready[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_ready_comb: got %b want 0", s_ready[0]);
        end
      end
      tick();
      if (i == 0) begin
        n_tests++;
        if (s_ready[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_ready_return: got %b want 1", s_ready[0]);
        end
      end
    end
    n_tests++;
    if (m_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: vld=%b want 0", m_valid[0]);
    end
  endtask

  task automatic test_hold();
    logic [31:0] words [4] = '{32'h1, 32'h2, 32'h3, 32'hDEAD};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data = words[i];
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    for (int c = 0; c < 3; c++) begin
      m_ready = c == 2;
      n_tests++;
      if (m_valid[0] !== 1'b1 || m_data[0] !== 32'hDEAD || m_last[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_c%0d: vld=%b data=%h last=%b, want 1 dead 1", c, m_valid[0], m_data[0], m_last[0]);
      end
      tick();
    end
    n_tests++;
    if (done[0] !== 1'b1 || m_valid[0] !== 1'b0 || bcount[0] !== 16'd1) begin
      n_fail++;
      $display("FAIL hold_accept: done=%b vld=%b cnt=%0d, want 1 0 1", done[0], m_valid[0], bcount[0]);
    end
  endtask

  task automatic test_input_tlast();
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 131; i++) begin
      s_valid = i < 130;
      s_last = i == 3;
      s_data = $urandom;
      tick();
      if (i < 130) begin
        n_tests++;
        if (m_last[1] !== (i == 63 || i == 127) || m_last[1] !== exp_last(1)) begin
          n_fail++;
          $display("FAIL tlast_word%0d: got %b want %b", i, m_last[1], i == 63 || i == 127);
        end
      end
    end
    s_last = 1'b0;
    n_tests++;
    if (bcount[1] !== 16'd2) begin
      n_fail++;
      $display("FAIL tlast_count: got %0d want 2", bcount[1]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 74; i++) begin
      s_data = 32'(i);
      tick();
    end
    m_ready = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bcount[1] !== 16'd1 || m_valid[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: cnt=%0d vld=%b, want 1 1", bcount[1], m_valid[1]);
    end
    aresetn = 1'b0;
    s_valid = 1'b0;
    tick();
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (m_valid[i] !== 1'b0 || bcount[i] !== 16'd0) begin
        n_fail++;
        $display("FAIL midrst_flush[%0d]: vld=%b cnt=%0d, want 0 0", i, m_valid[i], bcount[i]);
      end
    end
    tick();
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      s_data = $urandom;
      tick();
      n_tests++;
      if (m_last[1] !== (i == 63)) begin
        n_fail++;
        $display("FAIL midrst_word%0d: last=%b want %b", i, m_last[1], i == 63);
      end
    end
    s_valid = 1'b0;
    tick();
    n_tests++;
    if (bcount[1] !== 16'd1 || done[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_count: cnt=%0d done=%b, want 1 1", bcount[1], done[1]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      aresetn = $urandom_range(0, 299) != 0;
      s_valid = $urandom_range(0, 3) != 0;
      s_last = $urandom_range(0, 1);
      s_data = $urandom;
      m_ready = (c / 200) % 2 == 0 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0;
      tick();
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (s_ready[i] !== exp_ready() || m_valid[i] !== (q.size() > 0) || m_data[i] !== exp_data()) begin
          n_fail++;
          $display("FAIL rand_stream[%0d]@%0d: rdy=%b vld=%b data=%h, want %b %b %h",
                   i, c, s_ready[i], m_valid[i], m_data[i], exp_ready(), q.size() > 0, exp_data());
        end
        n_tests++;
        if (m_last[i] !== exp_last(i) || done[i] !== exp_done(i) || bcount[i] !== exp_count(i)) begin
          n_fail++;
          $display("FAIL rand_frame[%0d]@%0d: last=%b done=%b cnt=%0d, want %b %b %0d",
                   i, c, m_last[i], done[i], bcount[i], exp_last(i), exp_done(i), exp_count(i));
        end
      end
    end
    aresetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_hold();
    test_input_tlast();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mlp_result_framer.md
# mlp_result_framer

Downstream stage of the MLP AXI-Stream coprocessor. Accepts the coprocessor's result stream, one 32-bit word per input sample, and buffers it in a small synchronous FIFO. Re-emits the words to the DMA S2MM channel with TLAST regenerated on the last word of every BATCH-word batch. Also reports batch-completion status.

## Interface
Parameters:
- DATA_WIDTH, 32, result word width
- BATCH, 64, results per batch; TLAST period; ≥1
- DEPTH, 16, FIFO depth in words; power of two, ≥2

Ports:
- ACLK  in  1  single clock, rising edge
- ARESETN  in  1  reset; synchronous, active-low
- S_AXIS_TVALID  in  1  result word valid (from coprocessor M_AXIS_TVALID)
- S_AXIS_TDATA  in  DATA_WIDTH  result word
- S_AXIS_TLAST  in  1  ignored
- S_AXIS_TREADY  out  1  framer can accept a word
- M_AXIS_TVALID  out  1  output word valid
- M_AXIS_TDATA  out  DATA_WIDTH  output word
- M_AXIS_TLAST  out  1  last word of the current batch
- M_AXIS_TREADY  in  1  DMA accepts the word
- batch_done  out  1  one-cycle pulse per completed batch
- batch_count  out  16  completed batches, wraps at 2^16

## Operation
- Push: S_AXIS_TVALID && S_AXIS_TREADY at the clock edge writes S_AXIS_TDATA at the write pointer.
- Pop: M_AXIS_TVALID && M_AXIS_TREADY at the clock edge advances the read pointer.
- FIFO is first-word-fall-through.
  - M_AXIS_TDATA = mem[rd_ptr] when non-empty.
  - M_AXIS_TDATA = 0 when empty.
- Occupancy counter: 0..DEPTH, width clog2(DEPTH)+1. Pointers: clog2(DEPTH) bits, wrap DEPTH-1→0.
- S_AXIS_TREADY = (occupancy != DEPTH) && out of reset.
  - When full, the framer refuses a push even if a pop happens in the same cycle.
  - No combinational path from M_AXIS_TREADY to S_AXIS_TREADY.
- M_AXIS_TVALID = (occupancy != 0).
- Simultaneous push and pop when not full and not empty: occupancy unchanged, both pointers advance.
- Pop on empty and push on full cannot occur by construction.
- Beat counter: 0..BATCH-1, counts output handshakes.
  - M_AXIS_TLAST = M_AXIS_TVALID && (beat == BATCH-1).
  - On a TLAST handshake: beat → 0, batch_count += 1, batch_done = 1 for the next cycle only.
- Input TLAST is never used; framing derives only from the beat count.
- AXIS rule: once M_AXIS_TVALID is high, TVALID, TDATA and TLAST hold until the handshake.

## Timing
- Reset (ARESETN low at an edge) clears pointers, occupancy, beat and batch_count.
  - Outputs during reset: M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, batch_done=0, batch_count=0, S_AXIS_TREADY=0.
  - S_AXIS_TREADY goes to 1 in the first cycle after ARESETN is sampled high.
- Reset mid-batch discards all buffered words and any partial batch. The beat count restarts at 0.
- Latency: a word pushed at edge k appears on M_AXIS (TVALID=1) in the cycle after edge k. Output is one cycle behind input.
- Throughput: one word per cycle in and out when not full and the DMA is ready.
- batch_done is asserted in the cycle after the TLAST handshake edge. batch_count updates at that same edge.
- BATCH=1: TLAST is set on every word.

## Structure
- Shared package mlp_pkg holds:
  - DATA_WIDTH (32)
  - the BATCH default (64)
  - the batch_count width (16)
  
  The coprocessor and its bench use the same package.
- Sub-module axis_sync_fifo (DATA_WIDTH, DEPTH): memory, pointers, occupancy, ready/valid.
- mlp_result_framer instantiates axis_sync_fifo and adds the beat counter, TLAST, batch_done and batch_count.

## Test plan
- Reset check: ARESETN low for 2 cycles.
  - During reset: all outputs 0, S_AXIS_TREADY=0.
  - Cycle after release: S_AXIS_TREADY=1, M_AXIS_TVALID=0.
- Streaming batch (BATCH=4, M_AXIS_TREADY=1): push 1,2,3,4,5.
  - Out 1,2,3,4,5, each one cycle after its push.
  - TLAST only on 4; batch_done pulses once, the cycle after 4; batch_count=1.
- Backpressure (DEPTH=16): M_AXIS_TREADY=0, push 0x100..0x10F.
  - After 16 pushes S_AXIS_TREADY=0 and the 17th word 0x110 is held off.
  - Raise M_AXIS_TREADY: words drain in order 0x100..0x10F; S_AXIS_TREADY returns to 1 one cycle after the first pop.
- Stable hold under stall: M_AXIS_TREADY toggles 1,0,0,1 while the TLAST word 0xDEAD is presented.
  - TVALID, TDATA=0xDEAD and TLAST stay constant until the accepting edge.
- Input TLAST ignored (BATCH=64): input TLAST asserted on word 3.
  - Output TLAST appears only on word 63 and again on word 127; batch_count=2.
- Mid-batch reset: after 10 of 64 words, pulse ARESETN low for 1 cycle.
  - FIFO empties and batch_count=0.
  - The next batch's TLAST falls on its 64th word after reset.
